// File: rtl/fetch_queue.sv
// Sequential instruction fetcher with a small {instr, pc} FIFO toward decode.
// Optional combinational response bypass: define FETCH_BYPASS_EN.
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  pc_src,
  input  logic [DATA_WIDTH-1:0] pc_target,
  input  logic                  stall_d,
  output logic                  valid_d,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus4_d
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h13);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] r_pc_f;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_req_pc;
  logic [DATA_WIDTH-1:0] r_instr [DEPTH];
  logic [DATA_WIDTH-1:0] r_pc    [DEPTH];
  logic [AW-1:0]         r_rd;
  logic [AW-1:0]         r_wr;
  logic [CW-1:0]         r_count;

  logic [CW-1:0] w_occ;
  logic          w_req;
  logic          w_fifo_v;
  logic          w_byp;
  logic          w_push;
  logic          w_pop;

  // Slots are reserved at issue time so a response always finds room.
  assign w_occ    = r_count + CW'(r_inflight);
  assign w_req    = !rst && !pc_src && (w_occ < CAP);
  assign w_fifo_v = (r_count != '0);

`ifdef FETCH_BYPASS_EN
  assign w_byp = !w_fifo_v && r_inflight && !pc_src;
`else
  assign w_byp = 1'b0;
`endif

  assign w_push = r_inflight && !pc_src && !(w_byp && !stall_d);
  assign w_pop  = w_fifo_v && !stall_d && !pc_src;

  assign imem_req  = w_req;
  assign imem_addr = r_pc_f;

  always_comb begin
    valid_d    = 1'b0;
    instr_d    = NOP;
    pc_d       = '0;
    pc_plus4_d = '0;
    if (w_fifo_v) begin
      valid_d    = 1'b1;
      instr_d    = r_instr[r_rd];
      pc_d       = r_pc[r_rd];
      pc_plus4_d = r_pc[r_rd] + FOUR;
    end else if (w_byp) begin
      valid_d    = 1'b1;
      instr_d    = imem_rdata;
      pc_d       = r_req_pc;
      pc_plus4_d = r_req_pc + FOUR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f     <= RESET_PC;
      r_inflight <= 1'b0;
      r_req_pc   <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
    end else if (pc_src) begin
      r_pc_f     <= {pc_target[DATA_WIDTH-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
    end else begin
      if (w_req) begin
        r_pc_f     <= r_pc_f + FOUR;
        r_inflight <= 1'b1;
        r_req_pc   <= r_pc_f;
      end else begin
        r_inflight <= 1'b0;
      end
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_instr[r_wr] <= imem_rdata;
      r_pc[r_wr]    <= r_req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic
// against a queue model of issued-but-undelivered fetches.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        stall_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;

  fetch_queue #(
    .DATA_WIDTH(32),
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .pc_src(pc_src),
    .pc_target(pc_target),
    .stall_d(stall_d),
    .valid_d(valid_d),
    .instr_d(instr_d),
    .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a >> 2;
  endfunction

  // Instruction memory: answers exactly one cycle after each request.
  logic        resp_v;
  logic [31:0] resp_a;
  initial resp_v = 1'b0;
  always @(posedge clk) begin
    resp_v <= imem_req;
    resp_a <= imem_addr;
  end
  assign imem_rdata = resp_v ? memf(resp_a) : 32'hDEAD_BEEF;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fetch;
  bit          m_known;
  int          now;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Check outputs mid-cycle, advance one clock, update the model.
  task automatic step();
    bit          e_req;
    bit          e_val;
    logic [31:0] hpc;
    #1;
    e_req = !rst && !pc_src && (q.size() < DEPTH);
    e_val = (q.size() > 0) && (q[0].cyc + LAT <= now);
    hpc   = (q.size() > 0) ? q[0].pc : 32'h0;
    if (rst) begin
      chk("req_in_rst", {31'b0, imem_req}, 32'h0);
    end else if (m_known) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      chk("imem_addr", imem_addr, m_fetch);
      chk("valid_d", {31'b0, valid_d}, {31'b0, e_val});
      if (e_val) begin
        chk("pc_d", pc_d, hpc);
        chk("instr_d", instr_d, memf(hpc));
        chk("pc_plus4_d", pc_plus4_d, hpc + 32'd4);
      end else begin
        chk("pc_d_empty", pc_d, 32'h0);
        chk("instr_d_empty", instr_d, 32'h13);
        chk("pc_plus4_empty", pc_plus4_d, 32'h0);
      end
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_fetch = RESET_PC;
      m_known = 1'b1;
    end else if (pc_src) begin
      q.delete();
      m_fetch = pc_target & 32'hFFFF_FFFC;
    end else begin
      if (e_val && !stall_d) void'(q.pop_front());
      if (e_req) begin
        q.push_back('{now, m_fetch});
        m_fetch = m_fetch + 32'd4;
      end
    end
    now++;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    pc_src    = 1'b1;
    pc_target = tgt;
    step();
    pc_src    = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    now       = 0;
    m_known   = 1'b0;
    m_fetch   = RESET_PC;
    rst       = 1'b1;
    pc_src    = 1'b0;
    pc_target = 32'h0;
    stall_d   = 1'b0;
    @(negedge clk);

    // Reset and fill
    repeat (2) step();
    rst = 1'b0;
    repeat (8) step();

    // Backpressure then release
    stall_d = 1'b1;
    repeat (10) step();
    stall_d = 1'b0;
    repeat (10) step();

    // Redirect with entries queued and a response due
    stall_d = 1'b1;
    repeat (3) step();
    stall_d = 1'b0;
    redirect(32'h100);
    repeat (6) step();

    // Redirect while stalled and full
    stall_d = 1'b1;
    repeat (6) step();
    redirect(32'h40);
    repeat (4) step();
    stall_d = 1'b0;
    repeat (6) step();

    // Mid-operation reset with a full queue
    stall_d = 1'b1;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst     = 1'b0;
    stall_d = 1'b0;
    #1;
    chk("post_rst_valid", {31'b0, valid_d}, 32'h0);
    chk("post_rst_instr", instr_d, 32'h13);
    chk("post_rst_pc", pc_d, 32'h0);
    chk("post_rst_addr", imem_addr, RESET_PC);
    repeat (6) step();

    // Address wrap
    redirect(32'hFFFF_FFFC);
    repeat (6) step();

    // Misaligned target
    redirect(32'h0000_0203);
    repeat (6) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom % 100) == 0;
      pc_src    = ($urandom % 20) == 0;
      pc_target = $urandom;
      stall_d   = ($urandom % 10) < 3;
      step();
    end
    rst     = 1'b0;
    pc_src  = 1'b0;
    stall_d = 1'b0;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch-side producer for the decode stage.
- Generates sequential instruction-memory requests and buffers returned instructions with their PC in a small FIFO.
- Presents instr_d / pc_d / pc_plus4_d with a valid/stall handshake.
- Redirects fetch and flushes all buffered or in-flight instructions when pc_src asserts.

Parameters:
- DATA_WIDTH, 32, instruction/address width.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  DATA_WIDTH  byte address of request (word aligned).
- imem_rdata  input  DATA_WIDTH  instruction; valid exactly one cycle after imem_req.
- pc_src  input  1  redirect strobe (taken branch/jump).
- pc_target  input  DATA_WIDTH  redirect address.
- stall_d  input  1  decode cannot accept this cycle.
- valid_d  output  1  instr_d/pc_d/pc_plus4_d hold a real instruction.
- instr_d  output  DATA_WIDTH  head instruction.
- pc_d  output  DATA_WIDTH  head PC.
- pc_plus4_d  output  DATA_WIDTH  head PC + 4.

Behaviour:
- State:
  - pc_f fetch PC.
  - inflight flag (1 = response due this cycle).
  - FIFO of {instr, pc}: DEPTH entries, rd/wr pointers plus count (0..DEPTH).
- Reset (rst=1 at edge): pc_f=RESET_PC, inflight=0, count=0, pointers=0. rst has priority over every other event, including mid-operation with a full FIFO or a response due.
- Empty FIFO outputs: valid_d=0, instr_d=32'h0000_0013 (NOP), pc_d=0, pc_plus4_d=0. These are also the reset values of all outputs.
- Issue:
  - imem_req = !rst && !pc_src && (count + inflight < DEPTH).
  - imem_addr = pc_f always.
  - On issue: pc_f <= pc_f+4 (wraps modulo 2^DATA_WIDTH), inflight <= 1; otherwise inflight <= 0.
  - The reservation guarantees a returning response always has a free slot. No backpressure on imem.
- Response: when inflight=1 and pc_src=0, push {imem_rdata, pc of that request} at the edge.
- Output: head entry driven from FIFO registers. valid_d = (count != 0). pc_plus4_d = head pc + 4.
- Pop: at the edge when valid_d && !stall_d && !pc_src.
- Simultaneous push and pop: count unchanged. Legal at count=DEPTH only via the reservation rule, so overflow never occurs.
- Redirect (pc_src=1 at edge t):
  - FIFO cleared (count=0, pointers reset); pc_f <= pc_target.
  - Response arriving at t is discarded. imem_req=0 at t, so nothing remains in flight.
  - Pop at t is suppressed.
  - First request to pc_target issues at t+1; its response arrives at t+2; valid_d=1 with pc_d=pc_target at t+3.
  - pc_src with rst: rst wins.
- Steady state, no stalls: one instruction per cycle after a 3-cycle fill.
- stall_d with valid_d=0 has no effect.
- Misaligned pc_target: bits [1:0] forced to 0 in pc_f.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When count=0 and inflight=1 (no redirect), the response is driven combinationally onto the outputs with valid_d=1.
  - If accepted (!stall_d), it is not written to the FIFO; if stalled, it is pushed.
  - Redirect-to-valid latency becomes 2 cycles (pc_target visible at t+2). Reset fill visible 1 cycle after the first request.
- Undefined: no bypass; latencies as in Behaviour. Both builds must pass every non-latency check.

Test Plan:
- Reset/fill: rst 2 cycles, mem[i]=i, no stall -> imem_addr 0,4,8,…. valid_d first high 2 cycles after first req with pc_d=0, instr_d=mem[0], pc_plus4_d=4; then pc_d 4,8,12 on consecutive cycles.
- Backpressure: stall_d=1 for 10 cycles once valid -> imem_req drops once count+inflight=4. Outputs hold pc_d=0 steady. After release, pc_d 0,4,8,12,16,20 with no gaps or duplicates.
- Redirect: pc_src=1, pc_target=0x100 with 3 entries queued and a response due -> valid_d=0 at t+1, imem_addr=0x100 at t+1, pc_d=0x100 at t+3. The discarded response never appears.
- Redirect while stalled and full: stall_d=1, count=4, pc_src=1, pc_target=0x40 -> FIFO empties, then 0x40,0x44 delivered once stall_d drops.
- Mid-operation reset: rst pulse with count=4 and inflight=1 -> next cycle valid_d=0, instr_d=0x00000013, pc_d=0, imem_addr=RESET_PC.
- Wrap: pc_target=32'hFFFF_FFFC -> delivered pc_d FFFF_FFFC then 0000_0000. pc_plus4_d of first = 0.
